// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers and stalls the pipe while busy.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_IN,
  input  logic [1:0]  Op_IN,
  input  logic [31:0] A_IN,
  input  logic [31:0] B_IN,
  input  logic        HiWrite_IN,
  input  logic        LoWrite_IN,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT,
  output logic        Busy_OUT,
  output logic        Done_OUT,
  output logic        DivByZero_OUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  op;
  logic [31:0] opnd;
  logic [32:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  cnt;
  logic        sgn_q;
  logic        sgn_r;
  logic        dbz;

  logic        is_div;
  logic        st_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        st_dbz;

  logic [32:0] mul_sum;
  logic [32:0] rem_s;
  logic [33:0] trial;
  logic [32:0] step_hi;
  logic [31:0] step_lo;

  logic [63:0] prod;
  logic [63:0] prod_f;
  logic [31:0] quot_f;
  logic [31:0] rem_f;

  assign is_div   = op[1];
  assign Busy_OUT = (state != IDLE);

  // Operand magnitudes and divide-by-zero detection at start
  always_comb begin
    st_signed = ~Op_IN[0];
    a_abs     = (st_signed && A_IN[31]) ? (~A_IN + 32'd1) : A_IN;
    b_abs     = (st_signed && B_IN[31]) ? (~B_IN + 32'd1) : B_IN;
    st_dbz    = Op_IN[1] && (B_IN == 32'd0);
  end

  // One shift-add or shift-subtract iteration
  always_comb begin
    mul_sum = {1'b0, acc_hi[31:0]}
            + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    rem_s   = {acc_hi[31:0], acc_lo[31]};
    trial   = {1'b0, rem_s} - {2'b00, opnd};
    step_hi = acc_hi;
    step_lo = acc_lo;
    if (is_div) begin
      if (!trial[33]) begin
        step_hi = trial[32:0];
        step_lo = {acc_lo[30:0], 1'b1};
      end else begin
        step_hi = rem_s;
        step_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, mul_sum[32:1]};
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // Sign correction of the magnitude results
  always_comb begin
    prod   = {acc_hi[31:0], acc_lo};
    prod_f = sgn_q ? (~prod + 64'd1) : prod;
    quot_f = sgn_q ? (~acc_lo + 32'd1) : acc_lo;
    rem_f  = sgn_r ? (~acc_hi[31:0] + 32'd1) : acc_hi[31:0];
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op            <= 2'd0;
      opnd          <= 32'd0;
      acc_hi        <= 33'd0;
      acc_lo        <= 32'd0;
      cnt           <= 5'd0;
      sgn_q         <= 1'b0;
      sgn_r         <= 1'b0;
      dbz           <= 1'b0;
      HI_OUT        <= 32'd0;
      LO_OUT        <= 32'd0;
      Done_OUT      <= 1'b0;
      DivByZero_OUT <= 1'b0;
    end else begin
      Done_OUT <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start_IN) begin
            op            <= Op_IN;
            sgn_q         <= st_signed & (A_IN[31] ^ B_IN[31]);
            sgn_r         <= st_signed & A_IN[31];
            cnt           <= 5'd0;
            dbz           <= st_dbz;
            DivByZero_OUT <= 1'b0;
            if (st_dbz) begin
              acc_hi <= {1'b0, A_IN};
              acc_lo <= 32'd0;
              opnd   <= 32'd0;
              state  <= FIX;
            end else if (Op_IN[1]) begin
              acc_hi <= 33'd0;
              acc_lo <= a_abs;
              opnd   <= b_abs;
              state  <= CALC;
            end else begin
              acc_hi <= 33'd0;
              acc_lo <= b_abs;
              opnd   <= a_abs;
              state  <= CALC;
            end
          end else begin
            if (HiWrite_IN) HI_OUT <= A_IN;
            if (LoWrite_IN) LO_OUT <= A_IN;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (dbz) begin
            HI_OUT        <= acc_hi[31:0];
            LO_OUT        <= 32'hFFFF_FFFF;
            DivByZero_OUT <= 1'b1;
          end else if (is_div) begin
            HI_OUT <= rem_f;
            LO_OUT <= quot_f;
          end else begin
            HI_OUT <= prod_f[63:32];
            LO_OUT <= prod_f[31:0];
          end
          Done_OUT <= 1'b1;
          cnt      <= 5'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit.
// Directed and random operations checked against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_IN;
  logic [1:0]  Op_IN;
  logic [31:0] A_IN;
  logic [31:0] B_IN;
  logic        HiWrite_IN;
  logic        LoWrite_IN;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;
  logic        Busy_OUT;
  logic        Done_OUT;
  logic        DivByZero_OUT;

  int vecs = 0;
  int errs = 0;

  ex_muldiv_unit dut (
    .clk           (clk),
    .reset         (reset),
    .Start_IN      (Start_IN),
    .Op_IN         (Op_IN),
    .A_IN          (A_IN),
    .B_IN          (B_IN),
    .HiWrite_IN    (HiWrite_IN),
    .LoWrite_IN    (LoWrite_IN),
    .HI_OUT        (HI_OUT),
    .LO_OUT        (LO_OUT),
    .Busy_OUT      (Busy_OUT),
    .Done_OUT      (Done_OUT),
    .DivByZero_OUT (DivByZero_OUT)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz,
    output int          lat
  );
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dz  = 1'b0;
    lat = 33;
    hi  = 32'd0;
    lo  = 32'd0;
    case (op)
      2'd0: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      2'd1: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dz  = 1'b1;
          lat = 1;
          hi  = a;
          lo  = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  task automatic run_op(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output int          lat,
    output int          busyc
  );
    Start_IN = 1'b1;
    Op_IN    = op;
    A_IN     = a;
    B_IN     = b;
    @(posedge clk); #1;
    Start_IN = 1'b0;
    lat   = 0;
    busyc = 0;
    while (!Done_OUT && lat < 40) begin
      if (Busy_OUT) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    hi = HI_OUT;
    lo = LO_OUT;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    Start_IN   = 1'b0;
    Op_IN      = 2'd0;
    A_IN       = 32'd0;
    B_IN       = 32'd0;
    HiWrite_IN = 1'b0;
    LoWrite_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({HI_OUT, LO_OUT, Busy_OUT, Done_OUT, DivByZero_OUT} !== 67'd0) begin
      errs++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b want all 0",
               HI_OUT, LO_OUT, Busy_OUT, Done_OUT, DivByZero_OUT);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                              32'hFFFFFFF9, 32'd100, 32'h80000000,
                              32'h64, 32'd2};
    logic [31:0] t_b  [8] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2,
                              32'd7, 32'hFFFFFFFF, 32'd0, 32'd3};
    logic [31:0] t_hi [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000,
                              32'hFFFFFFFF, 32'd2, 32'd0, 32'h64, 32'd0};
    logic [31:0] t_lo [8] = '{32'h00000001, 32'hFFFFFFEB, 32'd0,
                              32'hFFFFFFFD, 32'd14, 32'h80000000,
                              32'hFFFFFFFF, 32'd6};
    logic        t_dz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] hi, lo;
    int          lat, busyc, want_lat;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], hi, lo, lat, busyc);
      want_lat = t_dz[i] ? 1 : 33;
      vecs++;
      if ({hi, lo} !== {t_hi[i], t_lo[i]}) begin
        errs++;
        $display("FAIL dir%0d result: got %h_%h want %h_%h",
                 i, hi, lo, t_hi[i], t_lo[i]);
      end
      vecs++;
      if (lat !== want_lat || busyc !== want_lat || Busy_OUT !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d timing: lat=%0d busy=%0d busy_now=%b want %0d/%0d/0",
                 i, lat, busyc, Busy_OUT, want_lat, want_lat);
      end
      vecs++;
      if (DivByZero_OUT !== t_dz[i]) begin
        errs++;
        $display("FAIL dir%0d dz: got %b want %b", i, DivByZero_OUT, t_dz[i]);
      end
      @(posedge clk); #1;
      vecs++;
      if (Done_OUT !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d done_pulse: got %b want 0", i, Done_OUT);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo, ehi, elo;
    logic        edz;
    int          lat, busyc, elat;
    for (int i = 0; i < 48; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 20));
      model(op, a, b, ehi, elo, edz, elat);
      run_op(op, a, b, hi, lo, lat, busyc);
      vecs++;
      if ({hi, lo} !== {ehi, elo}) begin
        errs++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h: got %h_%h want %h_%h",
                 i, op, a, b, hi, lo, ehi, elo);
      end
      vecs++;
      if (lat !== elat || busyc !== elat) begin
        errs++;
        $display("FAIL rnd%0d timing: lat=%0d busy=%0d want %0d",
                 i, lat, busyc, elat);
      end
      vecs++;
      if (DivByZero_OUT !== edz) begin
        errs++;
        $display("FAIL rnd%0d dz: got %b want %b", i, DivByZero_OUT, edz);
      end
    end
  endtask

  task automatic test_ignore;
    int n;
    Start_IN = 1'b1;
    Op_IN    = 2'd1;
    A_IN     = 32'd5;
    B_IN     = 32'd6;
    @(posedge clk); #1;
    Start_IN = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    Start_IN   = 1'b1;
    HiWrite_IN = 1'b1;
    LoWrite_IN = 1'b1;
    Op_IN      = 2'd2;
    A_IN       = 32'hDEADBEEF;
    B_IN       = 32'd0;
    @(posedge clk); #1;
    Start_IN   = 1'b0;
    HiWrite_IN = 1'b0;
    LoWrite_IN = 1'b0;
    n = 5;
    while (!Done_OUT && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (n !== 33 || {HI_OUT, LO_OUT} !== {32'd0, 32'd30}
        || DivByZero_OUT !== 1'b0) begin
      errs++;
      $display("FAIL ignore_busy: lat=%0d hi=%h lo=%h dz=%b want 33/0/1e/0",
               n, HI_OUT, LO_OUT, DivByZero_OUT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    Start_IN = 1'b1;
    Op_IN    = 2'd3;
    A_IN     = 32'd1000;
    B_IN     = 32'd9;
    @(posedge clk); #1;
    Start_IN = 1'b0;
    n = 0;
    while (!Done_OUT && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (n !== 33 || {HI_OUT, LO_OUT} !== {32'd1, 32'd111}) begin
      errs++;
      $display("FAIL b2b_first: lat=%0d hi=%h lo=%h want 33/1/6f",
               n, HI_OUT, LO_OUT);
    end
    Start_IN = 1'b1;
    Op_IN    = 2'd0;
    A_IN     = 32'hFFFFFFFF;
    B_IN     = 32'd12345;
    @(posedge clk); #1;
    Start_IN = 1'b0;
    vecs++;
    if (Busy_OUT !== 1'b1) begin
      errs++;
      $display("FAIL b2b_accept: busy=%b want 1", Busy_OUT);
    end
    n = 0;
    while (!Done_OUT && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (n !== 33 || {HI_OUT, LO_OUT} !== {32'hFFFFFFFF, 32'hFFFFCFC7}) begin
      errs++;
      $display("FAIL b2b_second: lat=%0d hi=%h lo=%h want 33/ffffffff/ffffcfc7",
               n, HI_OUT, LO_OUT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int dones;
    Start_IN = 1'b1;
    Op_IN    = 2'd2;
    A_IN     = 32'd77;
    B_IN     = 32'd5;
    @(posedge clk); #1;
    Start_IN = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vecs++;
    if ({HI_OUT, LO_OUT, Busy_OUT, Done_OUT, DivByZero_OUT} !== 67'd0) begin
      errs++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b dz=%b want all 0",
               HI_OUT, LO_OUT, Busy_OUT, Done_OUT, DivByZero_OUT);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done_OUT) dones++;
    end
    vecs++;
    if (dones !== 0 || {HI_OUT, LO_OUT} !== 64'd0) begin
      errs++;
      $display("FAIL reset_abort: dones=%0d hi=%h lo=%h want 0/0/0",
               dones, HI_OUT, LO_OUT);
    end
    A_IN       = 32'h1234;
    LoWrite_IN = 1'b1;
    @(posedge clk); #1;
    LoWrite_IN = 1'b0;
    vecs++;
    if ({HI_OUT, LO_OUT} !== {32'd0, 32'h1234}) begin
      errs++;
      $display("FAIL mtlo: hi=%h lo=%h want 0/1234", HI_OUT, LO_OUT);
    end
    A_IN       = 32'hCAFEF00D;
    HiWrite_IN = 1'b1;
    LoWrite_IN = 1'b1;
    @(posedge clk); #1;
    HiWrite_IN = 1'b0;
    LoWrite_IN = 1'b0;
    vecs++;
    if ({HI_OUT, LO_OUT, Busy_OUT} !== {32'hCAFEF00D, 32'hCAFEF00D, 1'b0}) begin
      errs++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b want cafef00d x2, 0",
               HI_OUT, LO_OUT, Busy_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage. It consumes operand A and operand B from the ID/EX pipeline register and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. It asserts a busy stall toward the hazard logic while an operation is in flight. Operations are radix-2: one bit per cycle, 32 iterations plus one sign-fixup cycle.

## Interface
- No parameters; data width is fixed at 32.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start_IN  input  1  request a new operation; sampled only in IDLE
- Op_IN  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A_IN  input  32  operand rs (multiplicand / dividend)
- B_IN  input  32  operand rt (multiplier / divisor)
- HiWrite_IN  input  1  MTHI: load HI_OUT from A_IN; honoured only in IDLE
- LoWrite_IN  input  1  MTLO: load LO_OUT from A_IN; honoured only in IDLE
- HI_OUT  output  32  HI register (product upper word / remainder)
- LO_OUT  output  32  LO register (product lower word / quotient)
- Busy_OUT  output  1  high whenever state != IDLE; drives pipeline stall
- Done_OUT  output  1  one-cycle pulse when HI/LO take a new result
- DivByZero_OUT  output  1  sticky; set by DIV/DIVU with B_IN = 0

## Operation
- Reset: state IDLE, HI_OUT = LO_OUT = 0, Busy_OUT = Done_OUT = DivByZero_OUT = 0, iteration counter = 0. Reset mid-operation aborts it; no partial result reaches HI/LO.
- States:
  - IDLE
  - CALC (counter 0..31)
  - FIX
- IDLE with Start_IN = 1:
  - Latch Op_IN.
  - Latch |A_IN| and |B_IN| (absolute value only for signed ops; |0x80000000| = 0x80000000 as an unsigned 32-bit value).
  - Latch the result signs:
    - product / quotient sign = A[31] ^ B[31]
    - remainder sign = A[31]
  - Clear DivByZero_OUT.
  - Go to CALC. Exception: for a divide with B_IN = 0, go directly to FIX.
- IDLE, Start_IN = 0:
  - HiWrite_IN loads HI_OUT = A_IN; LoWrite_IN loads LO_OUT = A_IN. Both may be asserted together.
  - If Start_IN = 1, HiWrite_IN and LoWrite_IN are ignored that cycle.
- CALC, multiply: uses a 65-bit accumulator {carry, hi, lo}, where lo is initialised to the multiplier magnitude. Each cycle:
  - If lo[0] = 1, add the multiplicand magnitude into {carry, hi}.
  - Shift the whole accumulator right by one.
- CALC, divide (restoring): uses a 33-bit remainder, where the quotient register is initialised to the dividend magnitude. Each cycle:
  - Shift {rem, quot} left by one.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and set quot[0] = 1.
- Counter reaching 31 moves the state to FIX.
- FIX:
  - Multiply: negate the 64-bit magnitude product (two's complement across HI:LO) when the sign is set.
  - Divide: negate the quotient and/or remainder per their signs.
  - Write HI/LO, assert Done_OUT for one cycle, go to IDLE.
  - Divide by zero: HI = A_IN as latched, LO = 0xFFFFFFFF, DivByZero_OUT = 1.
- Overflow: signed DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. It wraps and no flag is raised.
- Start_IN, HiWrite_IN and LoWrite_IN asserted while Busy_OUT = 1 are ignored; there is no queueing.

## Timing
- Start accepted at rising edge k:
  - Busy_OUT is high after edges k through k+32.
  - HI/LO are updated, Done_OUT = 1 and Busy_OUT = 0 after edge k+33. Latency is 33 cycles.
- Divide by zero accepted at edge k: FIX after edge k, with result and Done_OUT after edge k+1.
- HI_OUT and LO_OUT hold their values at all times except in the FIX-exit cycle and on IDLE MTHI/MTLO writes.
- Done_OUT is a single-cycle pulse that drops at the next edge. A new start may be accepted in the same cycle that Done_OUT is high, because the state is IDLE.
- The ID/EX register captures on the falling clock edge, so Busy_OUT is stable half a cycle before it is sampled. The stall is therefore visible to ID in the same cycle.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, Done_OUT pulses once, Busy_OUT high for exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x64 B=0 -> Done_OUT after 2 edges, HI=0x64, LO=0xFFFFFFFF, DivByZero_OUT=1. A following MULTU 2x3 clears the flag and gives LO=6.
- Start a MULTU at cycle 0, pulse Start_IN and HiWrite_IN at cycle 5 -> both ignored, result unchanged. Issue a back-to-back start in the Done_OUT cycle -> accepted, second result 33 cycles later.
- Assert reset at cycle 10 of a DIV -> next cycle IDLE, all outputs 0, no Done_OUT. Then MTLO with A_IN=0x1234 -> LO_OUT=0x1234.
